// File: rtl/pipeline_stage_buffer.sv
// Elastic buffer between adjacent pipeline stages: payload and control sideband
// share one circular buffer entry, with valid/ready handshakes and a squash flush.

module pipeline_stage_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_data_i,
    output logic [CTRL_WIDTH-1:0] ctrl_data_o,
    input  logic                  axis_s_data_tvalid,
    output logic                  axis_s_data_tready,
    input  logic [DATA_WIDTH-1:0] axis_s_data_tdata,
    output logic                  axis_m_data_tvalid,
    input  logic                  axis_m_data_tready,
    output logic [DATA_WIDTH-1:0] axis_m_data_tdata,
    output logic [CNT_WIDTH-1:0]  count_o
);

    localparam int ENTRY_WIDTH = DATA_WIDTH + CTRL_WIDTH;
    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Circular increment that also works for depths that are not a power of two.
    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == PTR_WIDTH'(DEPTH - 1)) begin
            return {PTR_WIDTH{1'b0}};
        end else begin
            return ptr + PTR_WIDTH'(1);
        end
    endfunction

    logic [ENTRY_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_r;
    logic [PTR_WIDTH-1:0]   rd_ptr_r;
    logic [CNT_WIDTH-1:0]   count_r;

    logic [PTR_WIDTH-1:0]   wr_ptr_nxt_s;
    logic [PTR_WIDTH-1:0]   rd_ptr_nxt_s;
    logic [CNT_WIDTH-1:0]   count_nxt_s;
    logic                   s_ready_s;
    logic                   m_valid_s;
    logic                   push_s;
    logic                   pop_s;
    logic [ENTRY_WIDTH-1:0] head_s;

    // Handshake qualifiers; ready never looks at the downstream ready.
    always_comb begin
        s_ready_s = (count_r != CNT_WIDTH'(DEPTH)) & ~flush_i;
        m_valid_s = (count_r != {CNT_WIDTH{1'b0}}) & ~flush_i;
        push_s    = axis_s_data_tvalid & s_ready_s;
        pop_s     = m_valid_s & axis_m_data_tready;
    end

    // Next pointer and occupancy; flush discards any concurrent transfer.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush_i) begin
            wr_ptr_nxt_s = {PTR_WIDTH{1'b0}};
            rd_ptr_nxt_s = {PTR_WIDTH{1'b0}};
            count_nxt_s  = {CNT_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = ptr_next(wr_ptr_r);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = ptr_next(rd_ptr_r);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_WIDTH'(1);
                2'b01:   count_nxt_s = count_r - CNT_WIDTH'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state register; reset outranks flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Entry storage is deliberately left unreset; contents matter only while valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {ctrl_data_i, axis_s_data_tdata};
        end
    end

    // Head-of-queue read and output mapping.
    always_comb begin
        head_s             = mem_r[rd_ptr_r];
        axis_m_data_tdata  = head_s[DATA_WIDTH-1:0];
        ctrl_data_o        = head_s[ENTRY_WIDTH-1:DATA_WIDTH];
        axis_s_data_tready = s_ready_s;
        axis_m_data_tvalid = m_valid_s;
        count_o            = count_r;
    end

    pipeline_stage_buffer_chk #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .count (count_r),
        .push  (push_s),
        .pop   (pop_s)
    );

endmodule

// Occupancy and handshake invariants for the stage buffer.
module pipeline_stage_buffer_chk #(
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input logic                 clk,
    input logic                 rst,
    input logic [CNT_WIDTH-1:0] count,
    input logic                 push,
    input logic                 pop
);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count <= CNT_WIDTH'(DEPTH));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
        pop |-> (count != {CNT_WIDTH{1'b0}}));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        push |-> (count != CNT_WIDTH'(DEPTH)));

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Directed bench: four buffer depths share one stimulus bus; each test
// observes the instance whose depth it targets.

module tb_pipeline_stage_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        svalid;
    logic [31:0] sdata;
    logic [15:0] sctrl;
    logic        mready;

    logic        d1_sready, d1_mvalid; logic [31:0] d1_data; logic [15:0] d1_ctrl; logic [0:0] d1_count;
    logic        d2_sready, d2_mvalid; logic [31:0] d2_data; logic [15:0] d2_ctrl; logic [1:0] d2_count;
    logic        d3_sready, d3_mvalid; logic [31:0] d3_data; logic [15:0] d3_ctrl; logic [1:0] d3_count;
    logic        d4_sready, d4_mvalid; logic [31:0] d4_data; logic [15:0] d4_ctrl; logic [2:0] d4_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_stage_buffer #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .flush_i(flush), .ctrl_data_i(sctrl), .ctrl_data_o(d1_ctrl),
        .axis_s_data_tvalid(svalid), .axis_s_data_tready(d1_sready), .axis_s_data_tdata(sdata),
        .axis_m_data_tvalid(d1_mvalid), .axis_m_data_tready(mready), .axis_m_data_tdata(d1_data),
        .count_o(d1_count));
    pipeline_stage_buffer #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush_i(flush), .ctrl_data_i(sctrl), .ctrl_data_o(d2_ctrl),
        .axis_s_data_tvalid(svalid), .axis_s_data_tready(d2_sready), .axis_s_data_tdata(sdata),
        .axis_m_data_tvalid(d2_mvalid), .axis_m_data_tready(mready), .axis_m_data_tdata(d2_data),
        .count_o(d2_count));
    pipeline_stage_buffer #(.DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush_i(flush), .ctrl_data_i(sctrl), .ctrl_data_o(d3_ctrl),
        .axis_s_data_tvalid(svalid), .axis_s_data_tready(d3_sready), .axis_s_data_tdata(sdata),
        .axis_m_data_tvalid(d3_mvalid), .axis_m_data_tready(mready), .axis_m_data_tdata(d3_data),
        .count_o(d3_count));
    pipeline_stage_buffer #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .flush_i(flush), .ctrl_data_i(sctrl), .ctrl_data_o(d4_ctrl),
        .axis_s_data_tvalid(svalid), .axis_s_data_tready(d4_sready), .axis_s_data_tdata(sdata),
        .axis_m_data_tvalid(d4_mvalid), .axis_m_data_tready(mready), .axis_m_data_tdata(d4_data),
        .count_o(d4_count));

    typedef struct {
        logic        flush;
        logic        svalid;
        logic [31:0] sdata;
        logic [15:0] sctrl;
        logic        mready;
        logic        exp_mvalid;
        logic        exp_sready;
        logic [2:0]  exp_count;
        logic [31:0] exp_data;
        logic [15:0] exp_ctrl;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush  = 1'b0;
        svalid = 1'b0;
        sdata  = 32'h0;
        sctrl  = 16'h0;
        mready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] q[$];
        logic [15:0] sv_pat;
        logic [15:0] mr_pat;
        int          pushes_n;
        int          pops_n;

        // Depth-4 fill/drain then flush-with-push; expectations seen before each edge.
        //           flush svalid sdata         sctrl    mready mvalid sready cnt   data          ctrl
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_00A0, 16'h10, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,         16'h0 };
        tbl[1]  = '{1'b0, 1'b1, 32'h0000_00A1, 16'h11, 1'b0, 1'b1, 1'b1, 3'd1, 32'h0000_00A0, 16'h10};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_00A2, 16'h12, 1'b0, 1'b1, 1'b1, 3'd2, 32'h0000_00A0, 16'h10};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_00A3, 16'h13, 1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_00A0, 16'h10};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_00B0, 16'h77, 1'b0, 1'b1, 1'b0, 3'd4, 32'h0000_00A0, 16'h10};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         16'h0,  1'b1, 1'b1, 1'b0, 3'd4, 32'h0000_00A0, 16'h10};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,         16'h0,  1'b1, 1'b1, 1'b1, 3'd3, 32'h0000_00A1, 16'h11};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,         16'h0,  1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_00A2, 16'h12};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,         16'h0,  1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_00A3, 16'h13};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,         16'h0,  1'b1, 1'b0, 1'b1, 3'd0, 32'h0,         16'h0 };
        tbl[10] = '{1'b0, 1'b1, 32'h0000_00C0, 16'h20, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,         16'h0 };
        tbl[11] = '{1'b0, 1'b1, 32'h0000_00C1, 16'h21, 1'b0, 1'b1, 1'b1, 3'd1, 32'h0000_00C0, 16'h20};
        tbl[12] = '{1'b0, 1'b1, 32'h0000_00C2, 16'h22, 1'b0, 1'b1, 1'b1, 3'd2, 32'h0000_00C0, 16'h20};
        tbl[13] = '{1'b1, 1'b1, 32'h0000_00FF, 16'hFF, 1'b1, 1'b0, 1'b0, 3'd3, 32'h0,         16'h0 };
        tbl[14] = '{1'b0, 1'b0, 32'h0,         16'h0,  1'b1, 1'b0, 1'b1, 3'd0, 32'h0,         16'h0 };
        tbl[15] = '{1'b0, 1'b1, 32'h0000_0055, 16'h05, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,         16'h0 };
        tbl[16] = '{1'b0, 1'b0, 32'h0,         16'h0,  1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_0055, 16'h05};
        tbl[17] = '{1'b0, 1'b0, 32'h0,         16'h0,  1'b0, 1'b0, 1'b1, 3'd0, 32'h0,         16'h0 };

        idle_inputs();
        rst = 1'b0;

        // Reset then idle
        do_reset();
        #3;
        check("reset_d2_mvalid", 32'(d2_mvalid), 32'd0);
        check("reset_d2_sready", 32'(d2_sready), 32'd1);
        check("reset_d2_count",  32'(d2_count),  32'd0);
        check("reset_d4_count",  32'(d4_count),  32'd0);
        tick();

        // Table-driven fill/drain/flush on depth 4
        do_reset();
        for (int i = 0; i < 18; i++) begin
            flush  = tbl[i].flush;
            svalid = tbl[i].svalid;
            sdata  = tbl[i].sdata;
            sctrl  = tbl[i].sctrl;
            mready = tbl[i].mready;
            #3;
            check($sformatf("vec%0d_mvalid", i), 32'(d4_mvalid), 32'(tbl[i].exp_mvalid));
            check($sformatf("vec%0d_sready", i), 32'(d4_sready), 32'(tbl[i].exp_sready));
            check($sformatf("vec%0d_count", i),  32'(d4_count),  32'(tbl[i].exp_count));
            if (tbl[i].exp_mvalid) begin
                check($sformatf("vec%0d_data", i), d4_data,       tbl[i].exp_data);
                check($sformatf("vec%0d_ctrl", i), 32'(d4_ctrl),  32'(tbl[i].exp_ctrl));
            end
            tick();
        end

        // Streaming on depth 2: one word per cycle after one cycle of latency
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            svalid = 1'b1;
            sdata  = 32'(k);
            sctrl  = 16'(k) ^ 16'h5A00;
            mready = 1'b1;
            #3;
            check($sformatf("stream%0d_sready", k), 32'(d2_sready), 32'd1);
            if (k == 0) begin
                check("stream0_mvalid", 32'(d2_mvalid), 32'd0);
                check("stream0_count",  32'(d2_count),  32'd0);
            end else begin
                check($sformatf("stream%0d_mvalid", k), 32'(d2_mvalid), 32'd1);
                check($sformatf("stream%0d_data", k),   d2_data,        32'(k - 1));
                check($sformatf("stream%0d_ctrl", k),   32'(d2_ctrl),   32'(16'(k - 1) ^ 16'h5A00));
                check($sformatf("stream%0d_count", k),  32'(d2_count),  32'd1);
            end
            tick();
        end

        // Depth 3 wrap-around with fixed irregular valid/ready patterns and a queue model
        do_reset();
        q.delete();
        sv_pat   = 16'b1110_1101_0111_1011;
        mr_pat   = 16'b1011_0010_1110_0101;
        pushes_n = 0;
        pops_n   = 0;
        for (int cyc = 0; cyc < 200 && pops_n < 10; cyc++) begin
            svalid = (pushes_n < 10) && sv_pat[cyc % 16];
            sdata  = 32'h300 + 32'(pushes_n);
            sctrl  = 16'h40 + 16'(pushes_n);
            mready = mr_pat[cyc % 16];
            #3;
            check($sformatf("wrap%0d_count", cyc),  32'(d3_count),  32'(q.size()));
            check($sformatf("wrap%0d_mvalid", cyc), 32'(d3_mvalid), 32'(q.size() != 0));
            check($sformatf("wrap%0d_sready", cyc), 32'(d3_sready), 32'(q.size() != 3));
            if (d3_mvalid && mready && q.size() != 0) begin
                check($sformatf("wrap_out%0d_data", pops_n), d3_data,      32'(q[0][31:0]));
                check($sformatf("wrap_out%0d_ctrl", pops_n), 32'(d3_ctrl), 32'(q[0][47:32]));
                void'(q.pop_front());
                pops_n++;
            end
            if (svalid && d3_sready) begin
                q.push_back({sctrl, sdata});
                pushes_n++;
            end
            tick();
        end
        check("wrap_outputs_seen", 32'(pops_n), 32'd10);

        // Reset mid-stream on depth 2 drops both held entries
        do_reset();
        svalid = 1'b1; sdata = 32'h400; sctrl = 16'h80;
        tick();
        sdata = 32'h401; sctrl = 16'h81;
        tick();
        svalid = 1'b0;
        #3;
        check("midrst_pre_count",  32'(d2_count),  32'd2);
        check("midrst_pre_mvalid", 32'(d2_mvalid), 32'd1);
        check("midrst_pre_sready", 32'(d2_sready), 32'd0);
        check("midrst_pre_data",   d2_data,        32'h400);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #3;
        check("midrst_post_count",  32'(d2_count),  32'd0);
        check("midrst_post_mvalid", 32'(d2_mvalid), 32'd0);
        check("midrst_post_sready", 32'(d2_sready), 32'd1);
        mready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            #3;
            check($sformatf("midrst_stale%0d", j), 32'(d2_mvalid), 32'd0);
        end
        tick();

        // Depth 1: continuous valid/ready gives one word every two cycles
        do_reset();
        for (int c = 0; c < 8; c++) begin
            svalid = 1'b1;
            sdata  = 32'h700 + 32'(c / 2);
            sctrl  = 16'h9 + 16'(c / 2);
            mready = 1'b1;
            #3;
            check($sformatf("d1_c%0d_sready", c), 32'(d1_sready), 32'((c % 2) == 0));
            check($sformatf("d1_c%0d_mvalid", c), 32'(d1_mvalid), 32'((c % 2) == 1));
            check($sformatf("d1_c%0d_count", c),  32'(d1_count),  32'(c % 2));
            if ((c % 2) == 1) begin
                check($sformatf("d1_c%0d_data", c), d1_data,      32'h700 + 32'((c - 1) / 2));
                check($sformatf("d1_c%0d_ctrl", c), 32'(d1_ctrl), 32'(16'h9 + 16'((c - 1) / 2)));
            end
            tick();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_buffer.md
Name: pipeline_stage_buffer

Overview:
Parametrised successor to the single-FIFO pipeline stage interconnect. It carries a data word and its control sideband through one shared circular buffer of DEPTH entries, so data and control can never desynchronise. The input and output use AXI-Stream-style valid/ready handshakes. It adds a synchronous flush for pipeline squash (branch or exception) and exposes occupancy. It sits between adjacent RISC-V pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_WIDTH, 32, payload width in bits.
CTRL_WIDTH, 16, control sideband width in bits; stored in the same entry as the payload.
DEPTH, 2, number of entries; any integer >= 1, not required to be a power of two.
CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy output (derived; do not override).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clk.
flush_i  input  1  synchronous squash; discards all stored entries.
ctrl_data_i  input  CTRL_WIDTH  control sideband, qualified by axis_s_data_tvalid.
ctrl_data_o  output  CTRL_WIDTH  control sideband of head entry.
axis_s_data_tvalid  input  1  upstream valid.
axis_s_data_tready  output  1  buffer can accept.
axis_s_data_tdata  input  DATA_WIDTH  upstream payload.
axis_m_data_tvalid  output  1  head entry valid.
axis_m_data_tready  input  1  downstream accept.
axis_m_data_tdata  output  DATA_WIDTH  payload of head entry.
count_o  output  CNT_WIDTH  current number of stored entries.

Behaviour:
- State: storage array of DEPTH x (DATA_WIDTH+CTRL_WIDTH); wr_ptr, rd_ptr in 0..DEPTH-1; count in 0..DEPTH.
- Pointer wrap: when a pointer equals DEPTH-1 and advances, it goes to 0. With DEPTH=1, both pointers stay at 0.
- push = axis_s_data_tvalid & axis_s_data_tready.
- pop = axis_m_data_tvalid & axis_m_data_tready.
- Writes happen only on push; reads advance only on pop. There are no writes on valid alone and no reads on ready alone.
- axis_s_data_tready = (count != DEPTH) & ~flush_i. It does not depend combinationally on axis_m_data_tready, so there is no ready path through the stage.
- axis_m_data_tvalid = (count != 0) & ~flush_i.
- axis_m_data_tdata and ctrl_data_o = storage[rd_ptr], combinational read. Both are held stable while tvalid=1 and tready=0.
- Latency: an entry pushed at edge N is presented with tvalid=1 in the cycle after edge N. Minimum latency is 1 cycle; there is no same-cycle bypass.
- Throughput: 1 entry/cycle when count is strictly between 0 and DEPTH. With DEPTH=1 the throughput is 1/2, because there is no push while full.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal whenever 0 < count < DEPTH.
- Full (count=DEPTH): tready=0; any asserted tvalid upstream is held off, and nothing is dropped. A pop at full frees the slot for the next cycle.
- Empty (count=0): tvalid=0. A pop cannot occur; axis_m_data_tready is ignored.
- Flush: when flush_i=1 at an edge, count<=0 and wr_ptr<=rd_ptr<=0.
  - Any concurrent push or pop is discarded; flush has priority.
  - Handshake outputs are forced low during the flush cycle.
  - Storage contents are not cleared; the output data value is don't-care while tvalid=0.
- Reset: rst=0 at an edge gives count=0, wr_ptr=0, rd_ptr=0. Reset has priority over flush.
  - During and after reset: axis_s_data_tready=1 (if not flushing), axis_m_data_tvalid=0, count_o=0.
  - Storage is not reset; data outputs are don't-care while tvalid=0.
  - Reset mid-stream drops all held entries.
- count_o = count, registered.
- Assertions (simulation only): count never exceeds DEPTH; no pop while count=0; no push while count=DEPTH.

Test Plan:
1. Reset then idle, DEPTH=2: hold rst=0 for 2 cycles then release -> tvalid=0, tready=1, count_o=0.
2. Fill and drain, DEPTH=4, m_tready=0: push 0xA0..0xA3 with ctrl 0x10..0x13 -> count_o reaches 4 and s_tready=0. Then raise m_tready -> outputs 0xA0/0x10 .. 0xA3/0x13 on 4 consecutive cycles, then tvalid=0.
3. Streaming, DEPTH=2: tvalid and tready held at 1 for 20 cycles with an incrementing payload -> one output per cycle after 1-cycle latency, in order, with count_o steady at 1.
4. Wrap-around, DEPTH=3 (non-power-of-2): 10 pushes and pops with random backpressure -> order preserved across the pointer wrap from 2 to 0, with the ctrl/data pairing intact.
5. Flush, DEPTH=4: with 3 entries held, assert flush_i together with a push of 0xFF -> next cycle count_o=0 and tvalid=0, and 0xFF is never emitted. The next push of 0x55 appears 1 cycle later.
6. Reset mid-operation, DEPTH=2: with count 2, pull rst low for 1 cycle while tvalid=1 -> count_o=0 and no stale entry is emitted afterwards. DEPTH=1 variant: alternating push/pop achieves 1 word per 2 cycles.
